// File: rtl/acia_pkg.sv
// ----------------------------------------------------------------------------
// acia_pkg
//   Shared definitions for the ACIA transmit buffer: launch FSM state
//   encoding, default FIFO depth and the lost-launch guard length.
// ----------------------------------------------------------------------------
package acia_pkg;

    localparam int TX_FIFO_DEPTH = 16;

    // Cycles spent waiting for tx_busy to rise before the launch is abandoned.
    localparam int BUSY_TIMEOUT  = 4;
    localparam int BUSY_TMR_W    = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//   Byte-wide circular buffer with registered occupancy flags.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     wr_stb_i        push request (wr_dat_i sampled with it)
//     wr_dat_i        byte to store
//     pop_i           advance the read pointer (caller guarantees not empty)
//     flush_i         synchronous clear of pointers, level and ovf
//     rd_dat_o        byte at the head of the queue (combinational read)
//     full_o/empty_o  registered occupancy flags
//     level_o         registered occupancy, 0..DEPTH
//     ovf_o           sticky: a push was dropped because the buffer was full
// ----------------------------------------------------------------------------
module byte_fifo
    import acia_pkg::*;
#(
    parameter  int DEPTH = TX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_stb_i,
    input  logic [7:0]    wr_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    rd_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          ovf_o
);

    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          push;
    logic          pop_ok;

    // A pop in the same cycle frees the slot, so a full buffer can still
    // accept the byte.
    assign push   = wr_stb_i & (~full_q | pop_i);
    assign pop_ok = pop_i & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            full_d  = 1'b0;
            empty_d = 1'b1;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            unique case ({push, pop_ok})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (wr_stb_i & ~push) begin
                ovf_d = 1'b1;
            end
            full_d  = (level_d == LVL_FULL);
            empty_d = (level_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage has no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push & ~flush_i) begin
            mem_q[wptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/acia_tx_fifo.sv
// ----------------------------------------------------------------------------
// acia_tx_fifo
//   Transmit buffer in front of the ACIA shifter. Queues CPU byte writes and
//   launches them one at a time with a tx_start pulse, pacing on tx_busy.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     wr_stb       one-cycle write strobe, wr_dat sampled with it
//     flush        synchronous clear of the queue and ovf
//     tx_busy      transmitter is shifting a byte
//     tx_dat       byte handed to the transmitter, held until next launch
//     tx_start     one-cycle launch pulse
//     full, empty  occupancy flags
//     level        occupancy, 0..DEPTH
//     ovf          sticky dropped-write flag
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | waiting for a queued byte and an idle transmitter
//   ST_WAIT_BUSY | byte launched, waiting for tx_busy to rise (timed guard)
//   ST_WAIT_DONE | transmitter shifting, waiting for tx_busy to fall
// ----------------------------------------------------------------------------
module acia_tx_fifo
    import acia_pkg::*;
#(
    parameter  int DEPTH = TX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_stb,
    input  logic [7:0]    wr_dat,
    input  logic          flush,
    input  logic          tx_busy,
    output logic [7:0]    tx_dat,
    output logic          tx_start,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [BUSY_TMR_W-1:0] TMR_LOAD = BUSY_TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [BUSY_TMR_W-1:0] TMR_ONE  = BUSY_TMR_W'(1);

    tx_state_e             state_q, state_d;
    logic [7:0]            tx_dat_q, tx_dat_d;
    logic                  tx_start_q, tx_start_d;
    logic [BUSY_TMR_W-1:0] tmr_q, tmr_d;
    logic                  pop;
    logic [7:0]            rd_dat;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_stb_i (wr_stb),
        .wr_dat_i (wr_dat),
        .pop_i    (pop),
        .flush_i  (flush),
        .rd_dat_o (rd_dat),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level),
        .ovf_o    (ovf)
    );

    always_comb begin
        state_d    = state_q;
        tx_dat_d   = tx_dat_q;
        tx_start_d = 1'b0;
        tmr_d      = tmr_q;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (~empty & ~tx_busy) begin
                    pop        = 1'b1;
                    tx_dat_d   = rd_dat;
                    tx_start_d = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    // Transmitter never acknowledged; give up on this launch.
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (~tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_dat_q   <= 8'h00;
            tx_start_q <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_dat_q   <= tx_dat_d;
            tx_start_q <= tx_start_d;
            tmr_q      <= tmr_d;
        end
    end

    assign tx_dat   = tx_dat_q;
    assign tx_start = tx_start_q;

endmodule

// File: tb/tb_acia_tx_fifo.sv
module tb_acia_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_stb = 1'b0;
    logic [7:0] wr_dat = 8'h00;
    logic       flush = 1'b0;
    logic       force_busy = 1'b0;
    logic       model_busy = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_dat;
    logic       tx_start;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;

    assign tx_busy = force_busy | model_busy;

    acia_tx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_stb   (wr_stb),
        .wr_dat   (wr_dat),
        .flush    (flush),
        .tx_busy  (tx_busy),
        .tx_dat   (tx_dat),
        .tx_start (tx_start),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    int busy_cnt = 0;
    int fall_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles after each start pulse. A launch
    // that follows a busy fall must come exactly one DUT edge after the edge
    // that first sees busy low (two negedges after the fall is driven).
    always @(negedge clk) begin
        if (tx_start) begin
            got.push_back(tx_dat);
            if (fall_cyc >= 0) begin
                chk("launch_gap", cyc - fall_cyc, 2);
                fall_cyc = -1;
            end
            model_busy = 1'b1;
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                model_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic       wr;
        logic [7:0] dat;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_tx_dat"}, int'(tx_dat), 0);
    endtask

    task automatic write_burst(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_stb = 1'b1;
            wr_dat = base + 8'(i);
            @(negedge clk);
        end
        wr_stb = 1'b0;
    endtask

    initial begin
        // Table for the fill-to-overflow run with the transmitter held busy.
        for (int i = 0; i < 17; i++) begin
            tbl[i].wr    = 1'b1;
            tbl[i].dat   = 8'(8'h10 + i);
            tbl[i].lvl   = (i + 1 > 16) ? 5'd16 : 5'(i + 1);
            tbl[i].full  = (i >= 15);
            tbl[i].empty = 1'b0;
            tbl[i].ovf   = (i == 16);
        end
        tbl[17] = '{wr: 1'b0, dat: 8'h00, lvl: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single byte latency and single pulse
        fall_cyc = -1;
        got.delete();
        wr_stb = 1'b1;
        wr_dat = 8'hA5;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("t1_empty_n1", int'(empty), 0);
        chk("t1_start_n1", int'(tx_start), 0);
        @(negedge clk);
        chk("t1_start_n2", int'(tx_start), 1);
        chk("t1_dat_n2", int'(tx_dat), 8'hA5);
        repeat (20) @(negedge clk);
        chk("t1_pulses", got.size(), 1);
        chk("t1_dat_hold", int'(tx_dat), 8'hA5);
        chk("t1_empty_end", int'(empty), 1);

        // 2: three bytes, paced by the transmitter model
        fall_cyc = -1;
        got.delete();
        write_burst(8'h01, 3);
        repeat (50) @(negedge clk);
        chk("t2_pulses", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk($sformatf("t2_byte%0d", i), int'(got[i]), i + 1);
        end

        // 3: fill past full with the transmitter held busy
        fall_cyc = -1;
        got.delete();
        force_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            wr_stb = tbl[i].wr;
            wr_dat = tbl[i].dat;
            @(negedge clk);
            chk($sformatf("t3_level_r%0d", i), int'(level), int'(tbl[i].lvl));
            chk($sformatf("t3_full_r%0d", i), int'(full), int'(tbl[i].full));
            chk($sformatf("t3_empty_r%0d", i), int'(empty), int'(tbl[i].empty));
            chk($sformatf("t3_ovf_r%0d", i), int'(ovf), int'(tbl[i].ovf));
        end
        wr_stb = 1'b0;
        chk("t3_no_launch", got.size(), 0);

        // 4: write on the same cycle as the first pop from a full buffer
        wr_stb = 1'b1;
        wr_dat = 8'hEE;
        force_busy = 1'b0;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("t4_level", int'(level), 16);
        chk("t4_full", int'(full), 1);
        chk("t4_ovf", int'(ovf), 1);
        chk("t4_start", int'(tx_start), 1);
        chk("t4_first", int'(tx_dat), 8'h10);
        repeat (260) @(negedge clk);
        chk("t34_pulses", got.size(), 17);
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            chk($sformatf("t34_byte%0d", i), int'(got[i]), (i < 16) ? (8'h10 + i) : 8'hEE);
        end
        chk("t34_empty", int'(empty), 1);
        chk("t34_ovf_sticky", int'(ovf), 1);

        // 5: flush with the first byte in flight
        fall_cyc = -1;
        got.delete();
        write_burst(8'hA0, 5);
        chk("t5_level_pre", int'(level), 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_level", int'(level), 0);
        chk("t5_ovf", int'(ovf), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_full", int'(full), 0);
        repeat (30) @(negedge clk);
        chk("t5_pulses", got.size(), 1);
        if (got.size() > 0) chk("t5_byte0", int'(got[0]), 8'hA0);

        // 6: asynchronous reset while waiting for the transmitter to finish
        fall_cyc = -1;
        got.delete();
        write_burst(8'hB0, 5);
        repeat (2) @(negedge clk);
        chk("t6_level_pre", int'(level), 4);
        chk("t6_dat_pre", int'(tx_dat), 8'hB0);
        chk("t6_busy_pre", int'(tx_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_launch", got.size(), 1);
        fall_cyc = -1;
        wr_stb = 1'b1;
        wr_dat = 8'hC3;
        @(negedge clk);
        wr_stb = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_pulses", got.size(), 2);
        if (got.size() > 1) chk("t6_new_byte", int'(got[1]), 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
